memory_bist: RTL and testbench

Parametrised single-port synchronous RAM with split read/write data buses and a built-in self-test (BIST) engine.
- BIST writes a descending-address counting pattern across every location, reads it back and compares each word.
- Reports pass/fail and the first failing address.
- Successor to the tristate-bus memory; used wherever on-chip RAM needs a power-up self-check without a testbench driving it.

---
 rtl/memory_bist.sv | 173 +++++++++++++++++
 tb/tb_memory_bist.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/memory_bist.sv
// rtl/memory_bist.sv - single-port RAM with descending counting-pattern BIST (optional MEMORY_BIST_INVERT_EN second pass)
module memory_bist #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int SEED   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [AWIDTH-1:0] fail_addr
);

    localparam int                DEPTH    = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] ADDR_MAX = {AWIDTH{1'b1}};
    localparam logic [DWIDTH-1:0] SEED_V   = DWIDTH'(SEED);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t            state;
    logic [DWIDTH-1:0] mem [DEPTH];

    // BIST walking address and pattern counter
    logic [AWIDTH-1:0] cnt;
    logic [DWIDTH-1:0] pat;
    logic [DWIDTH-1:0] pat_word;
    logic              rd_issue;

    // one-cycle compare pipeline: captured word, its expected value and address
    logic              cmp_valid;
    logic [DWIDTH-1:0] cmp_data;
    logic [DWIDTH-1:0] cmp_exp;
    logic [AWIDTH-1:0] cmp_addr;

    logic              func_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;

`ifdef MEMORY_BIST_INVERT_EN
    logic              inv_pass;
    assign pat_word = inv_pass ? ~pat : pat;
`else
    assign pat_word = pat;
`endif

    assign func_en = (state == IDLE) || (state == DONE);

    // Write port arbitration: the BIST owns the array while writing its pattern
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wdata;
        if (state == WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = pat_word;
        end else if (func_en && wr) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // BIST sequencer, functional read register and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rdata     <= '0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            cnt       <= '0;
            pat       <= '0;
            rd_issue  <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_data  <= '0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
`ifdef MEMORY_BIST_INVERT_EN
            inv_pass  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (rd && !wr) begin
                        rdata <= mem[addr];
                    end
                    if (bist_start) begin
                        state     <= WRITE;
                        bist_busy <= 1'b1;
                        bist_done <= 1'b0;
                        bist_fail <= 1'b0;
                        fail_addr <= '0;
                        cnt       <= ADDR_MAX;
                        pat       <= SEED_V;
`ifdef MEMORY_BIST_INVERT_EN
                        inv_pass  <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    cnt <= cnt - 1'b1;
                    pat <= pat + 1'b1;
                    if (cnt == '0) begin
                        state     <= READ;
                        cnt       <= ADDR_MAX;
                        pat       <= SEED_V;
                        rd_issue  <= 1'b1;
                        cmp_valid <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        cmp_data  <= mem[cnt];
                        cmp_exp   <= pat_word;
                        cmp_addr  <= cnt;
                        cmp_valid <= 1'b1;
                        cnt       <= cnt - 1'b1;
                        pat       <= pat + 1'b1;
                        if (cnt == '0) begin
                            rd_issue <= 1'b0;
                        end
                    end
                    if (cmp_valid && (cmp_data != cmp_exp)) begin
                        // first mismatch ends the run immediately
                        state     <= DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                        bist_fail <= 1'b1;
                        fail_addr <= cmp_addr;
                        rd_issue  <= 1'b0;
                        cmp_valid <= 1'b0;
                    end else if (!rd_issue) begin
                        // last compare of this pass came back clean
                        cmp_valid <= 1'b0;
`ifdef MEMORY_BIST_INVERT_EN
                        if (!inv_pass) begin
                            inv_pass <= 1'b1;
                            state    <= WRITE;
                            cnt      <= ADDR_MAX;
                            pat      <= SEED_V;
                        end else begin
                            state     <= DONE;
                            bist_busy <= 1'b0;
                            bist_done <= 1'b1;
                        end
`else
                        state     <= DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bist.sv
// tb/tb_memory_bist.sv - scoreboard bench for memory_bist
module tb_memory_bist;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
`ifdef MEMORY_BIST_INVERT_EN
    localparam int  BUSY_PASS = 130;
    localparam bit  FINAL_INV = 1'b1;
`else
    localparam int  BUSY_PASS = 65;
    localparam bit  FINAL_INV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          bist_start = 1'b0;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_fail;
    logic [AW-1:0] fail_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_rdata = '0;
    logic [DW-1:0] exp_q [$];
    int            cyc;

    memory_bist #(.AWIDTH(AW), .DWIDTH(DW), .SEED(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_fail  (bist_fail),
        .fail_addr  (fail_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one functional cycle; expected rdata is queued at drive time, popped after the edge
    task automatic access(input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag);
        wr = w; rd = r; addr = a; wdata = d;
        if (r && !w) exp_rdata = model_mem[a];
        if (w) model_mem[a] = d;
        exp_q.push_back(exp_rdata);
        tick();
        wr = 1'b0; rd = 1'b0;
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic fill_model(input bit inv);
        logic [DW-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            v = DW'(DEPTH - 1 - a);
            model_mem[a] = inv ? ~v : v;
        end
    endtask

    // pulse start, count cycles with busy high; optional fault deposit and disturbance
    task automatic run_bist(output int cycles, input int inject_at, input bit disturb);
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        cycles = 0;
        while (bist_busy && cycles < 1000) begin
            cycles++;
            if (cycles == inject_at) dut.mem[10] = 8'hFF;
            if (disturb && cycles == 10) bist_start = 1'b1;
            if (disturb && cycles == 11) bist_start = 1'b0;
            if (disturb && cycles == 20) begin wr = 1'b1; addr = 5'd31; wdata = 8'h77; end
            if (disturb && cycles == 21) wr = 1'b0;
            tick();
        end
        bist_start = 1'b0;
        wr = 1'b0;
        if (cycles >= 1000) check("bist_timeout", 32'(cycles), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_rdata", rdata, 0);
        check("rst_busy", bist_busy, 0);
        check("rst_done", bist_done, 0);
        #10 rst = 1'b0;

        access(1'b1, 1'b0, 5'd3, 8'hA5, "wr_hold");
        access(1'b0, 1'b1, 5'd3, 8'h00, "rd_a5");
        access(1'b1, 1'b1, 5'd7, 8'h3C, "wrrd_hold");
        access(1'b0, 1'b1, 5'd7, 8'h00, "rd_3c");

        run_bist(cyc, 0, 1'b1);
        check("pass_busy_cycles", 32'(cyc), 32'(BUSY_PASS));
        check("pass_done", bist_done, 1);
        check("pass_fail", bist_fail, 0);
        check("pass_fail_addr", fail_addr, 0);
        access(1'b0, 1'b0, 5'd0, 8'h00, "rdata_hold_bist");
        fill_model(FINAL_INV);
        access(1'b0, 1'b1, 5'd31, 8'h00, "pat_addr31");
        access(1'b0, 1'b1, 5'd0, 8'h00, "pat_addr0");
        access(1'b0, 1'b1, 5'd16, 8'h00, "pat_addr16");

        #3 rst = 1'b1;
        #1;
        check("midrst_rdata", rdata, 0);
        check("midrst_busy", bist_busy, 0);
        check("midrst_done", bist_done, 0);
        check("midrst_fail", bist_fail, 0);
        check("midrst_fail_addr", fail_addr, 0);
        #1 rst = 1'b0;
        exp_rdata = '0;
        tick();

        run_bist(cyc, 40, 1'b0);
        check("fail_busy_cycles", 32'(cyc), 32'd55);
        check("fail_done", bist_done, 1);
        check("fail_flag", bist_fail, 1);
        check("fail_addr", fail_addr, 32'd10);

        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        repeat (20) tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", bist_busy, 0);
        check("abort_done", bist_done, 0);
        check("abort_fail", bist_fail, 0);
        #1 rst = 1'b0;
        exp_rdata = '0;
        tick();
        run_bist(cyc, 0, 1'b0);
        check("rerun_busy_cycles", 32'(cyc), 32'(BUSY_PASS));
        check("rerun_done", bist_done, 1);
        check("rerun_fail", bist_fail, 0);
        fill_model(FINAL_INV);
        access(1'b0, 1'b1, 5'd31, 8'h00, "rerun_addr31");
        access(1'b0, 1'b1, 5'd10, 8'h00, "rerun_addr10");
        access(1'b0, 1'b1, 5'd0, 8'h00, "rerun_addr0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
